operand_fetch: RTL and testbench

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/riscv_pkg.sv | 17 +
 rtl/fwd_mux.sv | 51 +++++
 rtl/operand_fetch.sv | 178 +++++++++++++++++
 tb/tb_operand_fetch.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: data width, register-index type, x0.
// Also holds the forward-source match helper used by the operand muxes.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef logic [4:0] reg_idx_t;

    localparam reg_idx_t REG_X0 = 5'd0;

    // A producer matches a consumer only when it writes, targets the same
    // register, and that register is not the hard-wired zero.
    function automatic logic src_hit(input logic we, input reg_idx_t rd, input reg_idx_t rs);
        return we && (rd == rs) && (rs != REG_X0);
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// Per-operand source select: x0 -> 0, then EX > MEM > WB > register file.
// Build option OPFETCH_FWD_EN: when undefined only WB is forwarded; the EX
// and MEM match flags are still reported so the caller can stall instead.
module fwd_mux #(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic [4:0]      rs,
    input  logic            ex_we,
    input  logic [4:0]      ex_rd,
    input  logic [XLEN-1:0] ex_data,
    input  logic            mem_we,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_data,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic [XLEN-1:0] rf_data,
    output logic [XLEN-1:0] op,
    output logic            ex_hit,
    output logic            mem_hit
);
    import riscv_pkg::*;

    logic wb_hit;

`ifndef OPFETCH_FWD_EN
    // Without bypassing the EX/MEM data paths are intentionally left open.
    logic unused_nofwd_data;
    assign unused_nofwd_data = ^{ex_data, mem_data};
`endif

    // Match detection and priority selection of the operand value.
    always_comb begin
        ex_hit  = src_hit(ex_we,  ex_rd,  rs);
        mem_hit = src_hit(mem_we, mem_rd, rs);
        wb_hit  = src_hit(wb_we,  wb_rd,  rs);
        op      = rf_data;
        if (rs == REG_X0) begin
            op = '0;
`ifdef OPFETCH_FWD_EN
        end else if (ex_hit) begin
            op = ex_data;
        end else if (mem_hit) begin
            op = mem_data;
`endif
        end else if (wb_hit) begin
            op = wb_data;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads the register file, resolves forwarding,
// detects load-use (and, without bypassing, RAW) hazards and hands a
// registered operand slot to execute with valid/ready handshaking.
// Build option OPFETCH_FWD_EN enables EX/MEM bypassing; otherwise any
// EX/MEM dependency stalls and only WB is forwarded.
module operand_fetch #(
    parameter int XLEN        = riscv_pkg::XLEN,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    output logic                   id_ready,
    input  logic [4:0]             id_rs1,
    input  logic [4:0]             id_rs2,
    input  logic [4:0]             id_rd,
    input  logic                   id_use_rs1,
    input  logic                   id_use_rs2,
    input  logic                   id_is_load,
    input  logic                   id_we,
    output logic [4:0]             rf_a1,
    output logic [4:0]             rf_a2,
    input  logic [XLEN-1:0]        rf_rd1,
    input  logic [XLEN-1:0]        rf_rd2,
    input  logic                   ex_fwd_we,
    input  logic [4:0]             ex_fwd_rd,
    input  logic [XLEN-1:0]        ex_fwd_data,
    input  logic                   mem_we,
    input  logic [4:0]             mem_rd,
    input  logic [XLEN-1:0]        mem_data,
    input  logic                   wb_we,
    input  logic [4:0]             wb_rd,
    input  logic [XLEN-1:0]        wb_data,
    output logic                   ex_valid,
    input  logic                   ex_ready,
    output logic [XLEN-1:0]        ex_op1,
    output logic [XLEN-1:0]        ex_op2,
    output logic [4:0]             ex_rd,
    output logic                   ex_is_load,
    output logic                   ex_we,
    input  logic                   flush,
    output logic [STALL_CNT_W-1:0] stall_cnt
);
    import riscv_pkg::*;

    logic                   ex_valid_q,   ex_valid_d;
    logic [XLEN-1:0]        ex_op1_q,     ex_op1_d;
    logic [XLEN-1:0]        ex_op2_q,     ex_op2_d;
    reg_idx_t               ex_rd_q,      ex_rd_d;
    logic                   ex_is_load_q, ex_is_load_d;
    logic                   ex_we_q,      ex_we_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q,  stall_cnt_d;

    logic            ex_src_we;
    logic [XLEN-1:0] op1_sel, op2_sel;
    logic            ex_hit1, ex_hit2, mem_hit1, mem_hit2;
    logic            adv, load_hz, raw_hz, hz, accept;

    assign rf_a1 = id_rs1;
    assign rf_a2 = id_rs2;

    // The EX result only exists for a valid, writing, non-load slot.
    assign ex_src_we = ex_fwd_we && ex_valid_q && ex_we_q && !ex_is_load_q;

    fwd_mux #(.XLEN(XLEN)) u_fwd_op1 (
        .rs      (id_rs1),
        .ex_we   (ex_src_we),
        .ex_rd   (ex_fwd_rd),
        .ex_data (ex_fwd_data),
        .mem_we  (mem_we),
        .mem_rd  (mem_rd),
        .mem_data(mem_data),
        .wb_we   (wb_we),
        .wb_rd   (wb_rd),
        .wb_data (wb_data),
        .rf_data (rf_rd1),
        .op      (op1_sel),
        .ex_hit  (ex_hit1),
        .mem_hit (mem_hit1)
    );

    fwd_mux #(.XLEN(XLEN)) u_fwd_op2 (
        .rs      (id_rs2),
        .ex_we   (ex_src_we),
        .ex_rd   (ex_fwd_rd),
        .ex_data (ex_fwd_data),
        .mem_we  (mem_we),
        .mem_rd  (mem_rd),
        .mem_data(mem_data),
        .wb_we   (wb_we),
        .wb_rd   (wb_rd),
        .wb_data (wb_data),
        .rf_data (rf_rd2),
        .op      (op2_sel),
        .ex_hit  (ex_hit2),
        .mem_hit (mem_hit2)
    );

`ifdef OPFETCH_FWD_EN
    // Bypassing resolves EX/MEM dependencies, so the match flags are unused.
    logic unused_hits;
    assign unused_hits = ^{ex_hit1, ex_hit2, mem_hit1, mem_hit2};
    assign raw_hz      = 1'b0;
`else
    // Without bypassing any used operand produced in EX or MEM must wait.
    assign raw_hz = id_valid && ((id_use_rs1 && (ex_hit1 || mem_hit1)) ||
                                 (id_use_rs2 && (ex_hit2 || mem_hit2)));
`endif

    // Handshake and hazard detection for the decode side.
    always_comb begin
        adv     = !ex_valid_q || ex_ready;
        load_hz = id_valid && ex_valid_q && ex_is_load_q && (ex_rd_q != REG_X0) &&
                  ((id_use_rs1 && (id_rs1 == ex_rd_q)) ||
                   (id_use_rs2 && (id_rs2 == ex_rd_q)));
        hz       = load_hz || raw_hz;
        id_ready = adv && !hz && !flush;
        accept   = id_valid && id_ready;
    end

    // Next state of the execute slot (flush > accept > bubble > hold) and
    // of the saturating stall counter.
    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_op1_d     = ex_op1_q;
        ex_op2_d     = ex_op2_q;
        ex_rd_d      = ex_rd_q;
        ex_is_load_d = ex_is_load_q;
        ex_we_d      = ex_we_q;
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (accept) begin
            ex_valid_d   = 1'b1;
            ex_op1_d     = op1_sel;
            ex_op2_d     = op2_sel;
            ex_rd_d      = id_rd;
            ex_is_load_d = id_is_load;
            ex_we_d      = id_we;
        end else if (adv) begin
            ex_valid_d = 1'b0;
        end

        stall_cnt_d = stall_cnt_q;
        if (id_valid && !id_ready && !flush && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // State registers; reset empties the slot and clears the counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q   <= 1'b0;
            ex_op1_q     <= '0;
            ex_op2_q     <= '0;
            ex_rd_q      <= REG_X0;
            ex_is_load_q <= 1'b0;
            ex_we_q      <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_op1_q     <= ex_op1_d;
            ex_op2_q     <= ex_op2_d;
            ex_rd_q      <= ex_rd_d;
            ex_is_load_q <= ex_is_load_d;
            ex_we_q      <= ex_we_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ex_op1     = ex_op1_q;
    assign ex_op2     = ex_op2_q;
    assign ex_rd      = ex_rd_q;
    assign ex_is_load = ex_is_load_q;
    assign ex_we      = ex_we_q;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: vector table plus hand-written
// sequences for load-use, back-pressure, RAW stalls, flush and reset.
// Expectations adapt to the OPFETCH_FWD_EN build option.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_ready;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2, id_is_load, id_we;
    logic [4:0]  rf_a1, rf_a2;
    logic [31:0] rf_rd1, rf_rd2;
    logic        ex_fwd_we;
    logic [4:0]  ex_fwd_rd;
    logic [31:0] ex_fwd_data;
    logic        mem_we;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_valid, ex_ready;
    logic [31:0] ex_op1, ex_op2;
    logic [4:0]  ex_rd;
    logic        ex_is_load, ex_we;
    logic        flush;
    logic [15:0] stall_cnt;

    logic [31:0] rf [32];
    int          tests = 0;
    int          fails = 0;
    int          exp_stall = 0;

    assign rf_rd1 = rf[rf_a1];
    assign rf_rd2 = rf[rf_a2];

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_is_load(id_is_load), .id_we(id_we),
        .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .ex_fwd_we(ex_fwd_we), .ex_fwd_rd(ex_fwd_rd), .ex_fwd_data(ex_fwd_data),
        .mem_we(mem_we), .mem_rd(mem_rd), .mem_data(mem_data),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_rd(ex_rd),
        .ex_is_load(ex_is_load), .ex_we(ex_we),
        .flush(flush), .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic        id_valid;
        logic [4:0]  rs1, rs2, rd;
        logic        use1, use2, is_load, we, flush;
        logic        mem_we;
        logic [4:0]  mem_rd;
        logic [31:0] mem_data;
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic        exp_ready, exp_valid;
        logic [31:0] exp_op1, exp_op2;
        logic [4:0]  exp_rd;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                          input logic [4:0] rd, input logic u1, input logic u2,
                          input logic ld, input logic we);
        id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
        id_use_rs1 = u1; id_use_rs2 = u2; id_is_load = ld; id_we = we;
    endtask

    task automatic clear_srcs();
        ex_fwd_we = 1'b0; ex_fwd_rd = 5'd0; ex_fwd_data = 32'h0;
        mem_we = 1'b0; mem_rd = 5'd0; mem_data = 32'h0;
        wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
        flush = 1'b0; ex_ready = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
        rf[0] = 32'hDEADBEEF;
        rf[3] = 32'h11;
        rf[4] = 32'h22;

        //          iv    rs1   rs2   rd    u1    u2    ld    we    fl    mwe   mrd   mdata      wwe   wrd   wdata      rdy   vld   op1           op2           erd
        vecs[0] = '{1'b1, 5'd3, 5'd4, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,     1'b0, 5'd0, 32'h0,     1'b1, 1'b1, 32'h11,       32'h22,       5'd1};
        vecs[1] = '{1'b1, 5'd0, 5'd3, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 32'hAA,    1'b1, 5'd5, 32'hBB,    1'b1, 1'b1, 32'h0,        32'h11,       5'd2};
        vecs[2] = '{1'b1, 5'd6, 5'd4, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,     1'b1, 5'd6, 32'hBB,    1'b1, 1'b1, 32'hBB,       32'h22,       5'd3};
        vecs[3] = '{1'b0, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,     1'b0, 5'd0, 32'h0,     1'b1, 1'b0, 32'h0,        32'h0,        5'd0};
        vecs[4] = '{1'b1, 5'd7, 5'd8, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,     1'b0, 5'd7, 32'hCC,    1'b1, 1'b1, 32'h1007,     32'h1008,     5'd4};
        vecs[5] = '{1'b1, 5'd6, 5'd6, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 32'h99,    1'b1, 5'd6, 32'h77,    1'b1, 1'b1, 32'h77,       32'h77,       5'd6};
        vecs[6] = '{1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0,     1'b0, 5'd0, 32'h0,     1'b0, 1'b0, 32'h0,        32'h0,        5'd0};

        rst = 1'b1;
        clear_srcs();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        check("reset ex_valid", {31'd0, ex_valid}, 32'd0);
        check("reset ex_op1", ex_op1, 32'd0);
        check("reset ex_op2", ex_op2, 32'd0);
        check("reset ex_rd", {27'd0, ex_rd}, 32'd0);
        check("reset ex_flags", {30'd0, ex_is_load, ex_we}, 32'd0);
        check("reset stall_cnt", {16'd0, stall_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Table-driven vectors: combinational id_ready before the edge,
        // registered slot contents after it.
        for (int i = 0; i < 7; i++) begin
            set_id(vecs[i].id_valid, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
                   vecs[i].use1, vecs[i].use2, vecs[i].is_load, vecs[i].we);
            flush = vecs[i].flush;
            mem_we = vecs[i].mem_we; mem_rd = vecs[i].mem_rd; mem_data = vecs[i].mem_data;
            wb_we = vecs[i].wb_we; wb_rd = vecs[i].wb_rd; wb_data = vecs[i].wb_data;
            #1;
            check($sformatf("vec%0d id_ready", i), {31'd0, id_ready}, {31'd0, vecs[i].exp_ready});
            if (i == 0) check("rf_a1 follows id_rs1", {27'd0, rf_a1}, {27'd0, vecs[i].rs1});
            tick();
            check($sformatf("vec%0d ex_valid", i), {31'd0, ex_valid}, {31'd0, vecs[i].exp_valid});
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d ex_op1", i), ex_op1, vecs[i].exp_op1);
                check($sformatf("vec%0d ex_op2", i), ex_op2, vecs[i].exp_op2);
                check($sformatf("vec%0d ex_rd", i), {27'd0, ex_rd}, {27'd0, vecs[i].exp_rd});
            end
            check($sformatf("vec%0d stall_cnt", i), {16'd0, stall_cnt}, exp_stall);
            $display("[TB] vec %0d: id_valid=%0b rs1=%0d rs2=%0d flush=%0b -> ex_valid=%0b op1=%0h op2=%0h",
                     i, vecs[i].id_valid, vecs[i].rs1, vecs[i].rs2, vecs[i].flush, ex_valid, ex_op1, ex_op2);
        end
        clear_srcs();

        // Load-use: load to x7, then a consumer of x7 stalls one cycle.
        set_id(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        check("load ex_valid", {31'd0, ex_valid}, 32'd1);
        check("load flags", {30'd0, ex_is_load, ex_we}, 32'd3);
        check("load ex_rd", {27'd0, ex_rd}, 32'd7);
        set_id(1'b1, 5'd3, 5'd7, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
        #1;
        check("loaduse id_ready", {31'd0, id_ready}, 32'd0);
        tick();
        exp_stall++;
        check("loaduse bubble", {31'd0, ex_valid}, 32'd0);
        check("loaduse stall_cnt", {16'd0, stall_cnt}, exp_stall);
        check("loaduse retry ready", {31'd0, id_ready}, 32'd1);
        tick();
        check("loaduse accept valid", {31'd0, ex_valid}, 32'd1);
        check("loaduse accept op1", ex_op1, 32'h11);
        check("loaduse accept op2", ex_op2, 32'h1007);
        $display("[TB] load-use: stall_cnt=%0d ex_op2=%0h", stall_cnt, ex_op2);

        // Back-pressure: execute not ready for three cycles, slot holds.
        ex_ready = 1'b0;
        set_id(1'b1, 5'd4, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("bp%0d id_ready", c), {31'd0, id_ready}, 32'd0);
            tick();
            exp_stall++;
            check($sformatf("bp%0d ex_valid", c), {31'd0, ex_valid}, 32'd1);
            check($sformatf("bp%0d ex_op1", c), ex_op1, 32'h11);
            check($sformatf("bp%0d ex_op2", c), ex_op2, 32'h1007);
            check($sformatf("bp%0d ex_rd", c), {27'd0, ex_rd}, 32'd3);
        end
        check("bp stall_cnt", {16'd0, stall_cnt}, exp_stall);
        ex_ready = 1'b1;
        #1;
        check("bp release ready", {31'd0, id_ready}, 32'd1);
        tick();
        check("bp accept op1", ex_op1, 32'h22);
        check("bp accept rd", {27'd0, ex_rd}, 32'd8);
        $display("[TB] back-pressure: stall_cnt=%0d ex_rd=%0d", stall_cnt, ex_rd);

        // ALU result in slot (rd=8) consumed by the next instruction.
        ex_fwd_we = 1'b1; ex_fwd_rd = 5'd8; ex_fwd_data = 32'h5A;
        set_id(1'b1, 5'd8, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1);
        #1;
`ifdef OPFETCH_FWD_EN
        check("ex fwd ready", {31'd0, id_ready}, 32'd1);
        tick();
        check("ex fwd op1", ex_op1, 32'h5A);
`else
        check("raw ex stall ready", {31'd0, id_ready}, 32'd0);
        tick();
        exp_stall++;
        check("raw ex bubble", {31'd0, ex_valid}, 32'd0);
        check("raw ex stall_cnt", {16'd0, stall_cnt}, exp_stall);
        tick();
        check("raw ex accept op1", ex_op1, 32'h1008);
`endif
        check("ex dep valid", {31'd0, ex_valid}, 32'd1);
        $display("[TB] ex dependency: ex_op1=%0h stall_cnt=%0d", ex_op1, stall_cnt);
        ex_fwd_we = 1'b0;

        // MEM and WB both write x5: MEM wins when bypassing, else stall.
        mem_we = 1'b1; mem_rd = 5'd5; mem_data = 32'hAA;
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hBB;
        set_id(1'b1, 5'd5, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b1);
        #1;
`ifdef OPFETCH_FWD_EN
        check("mem fwd ready", {31'd0, id_ready}, 32'd1);
        tick();
        check("mem fwd op1", ex_op1, 32'hAA);
`else
        check("raw mem stall ready", {31'd0, id_ready}, 32'd0);
        tick();
        exp_stall++;
        check("raw mem bubble", {31'd0, ex_valid}, 32'd0);
        mem_we = 1'b0;
        tick();
        check("wb only op1", ex_op1, 32'hBB);
        mem_we = 1'b1;
`endif
        check("mem/wb stall_cnt", {16'd0, stall_cnt}, exp_stall);
        set_id(1'b1, 5'd0, 5'd0, 5'd11, 1'b1, 1'b0, 1'b0, 1'b1);
        #1;
        check("x0 ready", {31'd0, id_ready}, 32'd1);
        tick();
        check("x0 op1", ex_op1, 32'h0);
        check("x0 valid", {31'd0, ex_valid}, 32'd1);
        $display("[TB] mem/wb priority and x0: ex_op1=%0h", ex_op1);
        clear_srcs();

        // Asynchronous reset mid-stream, then normal one-cycle acceptance.
        set_id(1'b1, 5'd3, 5'd4, 5'd12, 1'b1, 1'b1, 1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("async rst ex_valid", {31'd0, ex_valid}, 32'd0);
        check("async rst stall_cnt", {16'd0, stall_cnt}, 32'd0);
        check("async rst ex_op1", ex_op1, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("post rst valid", {31'd0, ex_valid}, 32'd1);
        check("post rst op1", ex_op1, 32'h11);
        check("post rst rd", {27'd0, ex_rd}, 32'd12);
        $display("[TB] reset mid-stream: ex_valid=%0b ex_op1=%0h", ex_valid, ex_op1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
